submatrix_tiler: RTL and testbench
==================================

// Module: submatrix_tiler
// PURPOSE
//   Downstream of the bit-stream grouper. Captures ROW_WIDTH-bit grouped rows,
//   one per rising edge of row_loaded, into an NUM_ROWS x ROW_WIDTH bit matrix.
//   Once the matrix is full, emits every SUB_SIZE x SUB_SIZE submatrix (tile) in
//   raster order over a valid/ready handshake, then rearms for the next frame.
// PARAMETERS
//   ROW_WIDTH   16  bits per grouped row = matrix columns
//   NUM_ROWS    16  rows per frame = matrix rows
//   SUB_SIZE    4   tile edge; must divide ROW_WIDTH and NUM_ROWS
//   ROW_CNT_W   5   width of rows_filled; must hold 0..NUM_ROWS
//   TILE_IDX_W  2   width of tile_row/tile_col; must hold 0..(dim/SUB_SIZE)-1
// PORTS
//   clock        in   1                  rising-edge clock
//   reset        in   1                  async, active-high; clears all state
//   row_in       in   ROW_WIDTH          grouped row, valid when row_loaded high
//   row_loaded   in   1                  row-ready level from grouper
//   sub_block    out  SUB_SIZE*SUB_SIZE  current tile, packed MSB-first
//   tile_row     out  TILE_IDX_W         tile row index of sub_block
//   tile_col     out  TILE_IDX_W         tile column index of sub_block
//   sub_valid    out  1                  sub_block/tile_row/tile_col valid
//   sub_ready    in   1                  consumer accepts tile
//   rows_filled  out  ROW_CNT_W          rows captured in current frame
//   frame_done   out  1                  1-cycle pulse after last tile accepted
//   overflow     out  1                  sticky: row arrived while not filling
// BEHAVIOUR
//   Reset: all outputs 0; FSM=FILL; row_loaded edge detector prev=0. Matrix
//     storage need not be cleared. Reset wins at any point, incl. mid-EMIT.
//   Row strobe: row_stb = row_loaded & ~prev (prev = row_loaded registered).
//     A level held high for N cycles yields exactly one strobe.
//   Bit mapping: matrix M[r][c] = row r, bit (ROW_WIDTH-1-c); column 0 is MSB.
//   Tile packing: sub_block[SUB_SIZE*SUB_SIZE-1-(i*SUB_SIZE+j)] =
//     M[tile_row*SUB_SIZE+i][tile_col*SUB_SIZE+j], i,j in 0..SUB_SIZE-1.
//   FSM FILL: on row_stb, store row_in at row index rows_filled; rows_filled+1.
//     On the strobe storing row NUM_ROWS-1 -> EMIT at next edge; sub_valid=1 the
//     cycle after that capture with tile (0,0); rows_filled reads NUM_ROWS.
//   FSM EMIT: sub_valid=1; sub_block/tile_row/tile_col stable until transfer
//     (sub_valid & sub_ready at a rising edge). After transfer, next tile is
//     presented the following cycle; tile_col advances fastest, wraps to 0 and
//     increments tile_row. Back-to-back transfers with sub_ready held high: one
//     tile per cycle. Tile count per frame = (NUM_ROWS/SUB_SIZE)*(ROW_WIDTH/SUB_SIZE).
//   Last tile transfer: sub_valid=0, frame_done=1 for exactly the next cycle,
//     rows_filled=0, tile_row=tile_col=0, FSM=FILL; new rows accepted from the
//     cycle frame_done is high.
//   row_stb while in EMIT: row dropped, matrix untouched, overflow set (sticky
//     until reset); tile stream continues unaffected.
//   sub_ready while sub_valid=0: ignored.
//   No combinational path from sub_ready or row_loaded to any output.
// TESTING
//   T1 fill: rows r=0..15 with row_in=16'h0001<<r, then sub_ready=1 -> 16 tiles
//     (0,0)..(3,3) back-to-back; tiles (0,3),(1,2),(2,1),(3,0)=16'h1248, all
//     others 16'h0000; sub_valid first high 1 cycle after 16th row captured.
//   T2 stall: hold sub_ready=0 for 10 cycles during EMIT -> sub_valid stays 1,
//     sub_block/tile indices unchanged; release -> stream resumes at same tile.
//   T3 level strobe: row_loaded held high 5 cycles -> rows_filled +1 only.
//   T4 overflow: strobe during EMIT -> overflow=1 and stays 1; tile data and
//     sequence identical to T1; rows_filled unchanged.
//   T5 frame end/restart: after 16th transfer -> frame_done pulse of 1 cycle,
//     rows_filled=0; second frame of all-ones rows -> 16 tiles of 16'hFFFF.
//   T6 reset mid-EMIT: assert reset at tile (1,2) -> all outputs 0 immediately
//     (async); after release, full T1 frame reproduces T1 results exactly.

Source files
------------

// File: rtl/submatrix_tiler.sv
// Collects grouped rows into a bit matrix. When the matrix is full it streams every
// SUB_SIZE x SUB_SIZE tile in raster order over valid/ready, then returns to filling.
module submatrix_tiler #(
  parameter int ROW_WIDTH  = 16,
  parameter int NUM_ROWS   = 16,
  parameter int SUB_SIZE   = 4,
  parameter int ROW_CNT_W  = 5,
  parameter int TILE_IDX_W = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ROW_WIDTH-1:0]           row_in,
  input  logic                           row_loaded,
  output logic [SUB_SIZE*SUB_SIZE-1:0]   sub_block,
  output logic [TILE_IDX_W-1:0]          tile_row,
  output logic [TILE_IDX_W-1:0]          tile_col,
  output logic                           sub_valid,
  input  logic                           sub_ready,
  output logic [ROW_CNT_W-1:0]           rows_filled,
  output logic                           frame_done,
  output logic                           overflow
);

  localparam int RI_W    = (NUM_ROWS  > 1) ? $clog2(NUM_ROWS)  : 1;
  localparam int CI_W    = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam int TR_LAST = NUM_ROWS / SUB_SIZE - 1;
  localparam int TC_LAST = ROW_WIDTH / SUB_SIZE - 1;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]                          r_state;
  logic                                r_prev;
  logic [ROW_CNT_W-1:0]                r_rows_filled;
  logic [TILE_IDX_W-1:0]               r_tile_row;
  logic [TILE_IDX_W-1:0]               r_tile_col;
  logic                                r_frame_done;
  logic                                r_overflow;
  logic [NUM_ROWS-1:0][ROW_WIDTH-1:0]  r_mat;

  logic                                w_row_stb;
  logic                                w_emit;
  logic                                w_col_last;
  logic                                w_last_tile;
  logic [RI_W-1:0]                     w_rbase;
  logic [CI_W-1:0]                     w_cbase;
  logic [SUB_SIZE*SUB_SIZE-1:0]        w_tile;

  // Rising edge of the grouper's level signal; a held level is one row.
  assign w_row_stb   = row_loaded & ~r_prev;
  assign w_emit      = (r_state == S_EMIT);
  assign w_col_last  = (r_tile_col == TILE_IDX_W'(TC_LAST));
  assign w_last_tile = w_col_last && (r_tile_row == TILE_IDX_W'(TR_LAST));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_FILL;
      r_prev        <= 1'b0;
      r_rows_filled <= '0;
      r_tile_row    <= '0;
      r_tile_col    <= '0;
      r_frame_done  <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_prev       <= row_loaded;
      r_frame_done <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_row_stb) begin
            r_rows_filled <= r_rows_filled + 1'b1;
            if (r_rows_filled == ROW_CNT_W'(NUM_ROWS - 1))
              r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_row_stb)
            r_overflow <= 1'b1;
          if (sub_ready) begin
            if (w_last_tile) begin
              r_state       <= S_FILL;
              r_frame_done  <= 1'b1;
              r_rows_filled <= '0;
              r_tile_row    <= '0;
              r_tile_col    <= '0;
            end else if (w_col_last) begin
              r_tile_col <= '0;
              r_tile_row <= r_tile_row + 1'b1;
            end else begin
              r_tile_col <= r_tile_col + 1'b1;
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  // Row storage is never cleared; only the write pointer and FSM are reset.
  always_ff @(posedge clock) begin
    if (w_row_stb && (r_state == S_FILL))
      r_mat[r_rows_filled[RI_W-1:0]] <= row_in;
  end

  assign w_rbase = RI_W'(r_tile_row) * RI_W'(SUB_SIZE);
  assign w_cbase = CI_W'(r_tile_col) * CI_W'(SUB_SIZE);

  // Column c of the matrix is row bit ROW_WIDTH-1-c; tiles pack row-major, MSB first.
  for (genvar i = 0; i < SUB_SIZE; i++) begin : g_trow
    logic [RI_W-1:0] w_ridx;
    assign w_ridx = w_rbase + RI_W'(i);
    for (genvar j = 0; j < SUB_SIZE; j++) begin : g_tcol
      logic [CI_W-1:0] w_bidx;
      assign w_bidx = CI_W'(ROW_WIDTH - 1) - (w_cbase + CI_W'(j));
      assign w_tile[SUB_SIZE*SUB_SIZE-1-(i*SUB_SIZE+j)] = r_mat[w_ridx][w_bidx];
    end
  end

  assign sub_block   = w_emit ? w_tile : '0;
  assign sub_valid   = w_emit;
  assign tile_row    = r_tile_row;
  assign tile_col    = r_tile_col;
  assign rows_filled = r_rows_filled;
  assign frame_done  = r_frame_done;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_submatrix_tiler.sv
// Directed bench for submatrix_tiler: fill, stall, level strobe, overflow,
// frame restart and asynchronous reset in the middle of a tile stream.
module tb_submatrix_tiler;

  logic        clock;
  logic        reset;
  logic [15:0] row_in;
  logic        row_loaded;
  logic [15:0] sub_block;
  logic [1:0]  tile_row;
  logic [1:0]  tile_col;
  logic        sub_valid;
  logic        sub_ready;
  logic [4:0]  rows_filled;
  logic        frame_done;
  logic        overflow;

  int n_vec;
  int n_err;

  submatrix_tiler dut (
    .clock       (clock),
    .reset       (reset),
    .row_in      (row_in),
    .row_loaded  (row_loaded),
    .sub_block   (sub_block),
    .tile_row    (tile_row),
    .tile_col    (tile_col),
    .sub_valid   (sub_valid),
    .sub_ready   (sub_ready),
    .rows_filled (rows_filled),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle row_loaded pulse; returns at the negedge after the capturing edge.
  task automatic send_row(input logic [15:0] d);
    @(negedge clock);
    row_in     = d;
    row_loaded = 1'b1;
    @(negedge clock);
    row_loaded = 1'b0;
  endtask

  // Anti-diagonal tiles hold 0x1248 for the one-hot fill; all-ones fill gives 0xFFFF.
  function automatic logic [15:0] exp_tile(input bit ones, input int r, input int c);
    if (ones) return 16'hFFFF;
    return (r + c == 3) ? 16'h1248 : 16'h0000;
  endfunction

  // Called at a negedge with sub_ready=1; ends at the negedge after the last transfer.
  task automatic collect(input bit ones, input string tag);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_t%0d_valid", tag, k), {31'd0, sub_valid}, 32'd1);
      chk($sformatf("%s_t%0d_row", tag, k), {30'd0, tile_row}, k / 4);
      chk($sformatf("%s_t%0d_col", tag, k), {30'd0, tile_col}, k % 4);
      chk($sformatf("%s_t%0d_blk", tag, k), {16'd0, sub_block}, {16'd0, exp_tile(ones, k / 4, k % 4)});
      @(negedge clock);
    end
    chk({tag, "_fdone"},  {31'd0, frame_done}, 32'd1);
    chk({tag, "_vld0"},   {31'd0, sub_valid},  32'd0);
    chk({tag, "_rows0"},  {27'd0, rows_filled}, 32'd0);
    chk({tag, "_trow0"},  {30'd0, tile_row},   32'd0);
    chk({tag, "_tcol0"},  {30'd0, tile_col},   32'd0);
  endtask

  task automatic fill_onehot(input string tag);
    for (int r = 0; r < 15; r++) send_row(16'h0001 << r);
    chk({tag, "_rows15"}, {27'd0, rows_filled}, 32'd15);
    chk({tag, "_vld_pre"}, {31'd0, sub_valid}, 32'd0);
    send_row(16'h8000);
    chk({tag, "_vld_post"}, {31'd0, sub_valid}, 32'd1);
    chk({tag, "_rows16"}, {27'd0, rows_filled}, 32'd16);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    row_in     = '0;
    row_loaded = 1'b0;
    sub_ready  = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_vld",   {31'd0, sub_valid},  32'd0);
    chk("rst_blk",   {16'd0, sub_block},  32'd0);
    chk("rst_rows",  {27'd0, rows_filled}, 32'd0);
    chk("rst_fdone", {31'd0, frame_done}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow},   32'd0);
    chk("rst_tile",  {28'd0, tile_row, tile_col}, 32'd0);
    reset = 1'b0;

    // T3: level held five cycles counts as one row (row 0 of frame 1)
    @(negedge clock);
    row_in     = 16'h0001;
    row_loaded = 1'b1;
    repeat (5) @(negedge clock);
    row_loaded = 1'b0;
    chk("lvl_rows1", {27'd0, rows_filled}, 32'd1);
    for (int r = 1; r < 15; r++) send_row(16'h0001 << r);
    chk("f1_rows15", {27'd0, rows_filled}, 32'd15);
    chk("f1_vld_pre", {31'd0, sub_valid}, 32'd0);
    send_row(16'h8000);
    chk("f1_vld_post", {31'd0, sub_valid}, 32'd1);
    chk("f1_rows16", {27'd0, rows_filled}, 32'd16);

    // T2: stall holds tile (0,0)
    for (int s = 0; s < 10; s++) begin
      chk($sformatf("stall%0d_vld", s), {31'd0, sub_valid}, 32'd1);
      chk($sformatf("stall%0d_tile", s), {28'd0, tile_row, tile_col}, 32'd0);
      chk($sformatf("stall%0d_blk", s), {16'd0, sub_block}, 32'd0);
      @(negedge clock);
    end

    // T4: strobe during EMIT is dropped and flags overflow
    row_in     = 16'hFFFF;
    row_loaded = 1'b1;
    @(negedge clock);
    row_loaded = 1'b0;
    chk("ovf_set",  {31'd0, overflow},    32'd1);
    chk("ovf_rows", {27'd0, rows_filled}, 32'd16);
    @(negedge clock);
    chk("ovf_hold", {31'd0, overflow},    32'd1);
    sub_ready = 1'b1;
    collect(1'b0, "f1");

    // T5: next frame starts in the frame_done cycle
    send_row(16'hFFFF);
    chk("f1_fdone_pulse", {31'd0, frame_done}, 32'd0);
    chk("f2_rows1", {27'd0, rows_filled}, 32'd1);
    chk("f2_ovf_sticky", {31'd0, overflow}, 32'd1);
    sub_ready = 1'b0;
    for (int r = 1; r < 16; r++) send_row(16'hFFFF);
    chk("f2_vld", {31'd0, sub_valid}, 32'd1);
    sub_ready = 1'b1;
    collect(1'b1, "f2");

    // T6: async reset while tile (1,2) is presented
    fill_onehot("f3");
    repeat (6) @(negedge clock);
    chk("f3_at12", {28'd0, tile_row, tile_col}, 32'h6);
    #2 reset = 1'b1;
    #1;
    chk("arst_vld",   {31'd0, sub_valid},  32'd0);
    chk("arst_blk",   {16'd0, sub_block},  32'd0);
    chk("arst_tile",  {28'd0, tile_row, tile_col}, 32'd0);
    chk("arst_rows",  {27'd0, rows_filled}, 32'd0);
    chk("arst_fdone", {31'd0, frame_done}, 32'd0);
    chk("arst_ovf",   {31'd0, overflow},   32'd0);
    sub_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    fill_onehot("f4");
    sub_ready = 1'b1;
    collect(1'b0, "f4");
    chk("f4_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clock);
    chk("f4_fdone_end", {31'd0, frame_done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
